// File: rtl/uart_tx_fifo_if.sv
// Handshake between the UART transmitter and the upstream FIFO it drains.
// master is the transmitter side, slave is the FIFO side.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_q_i;
  logic                  fifo_empty_i;
  logic                  fifo_deq_o;

  modport master (
    input  fifo_q_i,
    input  fifo_empty_i,
    output fifo_deq_o
  );

  modport slave (
    output fifo_q_i,
    output fifo_empty_i,
    input  fifo_deq_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1-style, LSB first) that pulls characters from an upstream FIFO.
// One dequeue per frame; the character is captured on the dequeue edge.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  uart_tx_fifo_if.master   fifo,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      baud_cnt, baud_nx;
  logic [IDX_W-1:0]      bit_idx, bit_nx;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nx;
  logic                  tx_reg, tx_nx;
  logic                  deq;

  // tx_nx is the line level for the next cycle, so tx_o stays a pure register
  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    shift_nx = shift_reg;
    tx_nx    = tx_reg;
    deq      = 1'b0;

    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!fifo.fifo_empty_i && !reset_i) begin
          deq      = 1'b1;
          shift_nx = fifo.fifo_q_i;
          baud_nx  = BAUD_RELOAD;
          bit_nx   = '0;
          tx_nx    = 1'b0;
          state_nx = START;
        end
      end

      START: begin
        if (baud_cnt == '0) begin
          baud_nx  = BAUD_RELOAD;
          bit_nx   = '0;
          tx_nx    = shift_reg[0];
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt - 1'b1;
        end
      end

      // Shift register moves right each bit so the next bit is always at [0]
      DATA: begin
        if (baud_cnt == '0) begin
          baud_nx = BAUD_RELOAD;
          if (bit_idx == LAST_BIT) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            bit_nx   = bit_idx + 1'b1;
            shift_nx = shift_reg >> 1;
            tx_nx    = shift_nx[0];
          end
        end else begin
          baud_nx = baud_cnt - 1'b1;
        end
      end

      STOP: begin
        tx_nx = 1'b1;
        if (baud_cnt == '0) begin
          baud_nx  = BAUD_RELOAD;
          state_nx = IDLE;
        end else begin
          baud_nx = baud_cnt - 1'b1;
        end
      end

      default: begin
        tx_nx    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_nx;
      baud_cnt  <= baud_nx;
      bit_idx   <= bit_nx;
      shift_reg <= shift_nx;
      tx_reg    <= tx_nx;
    end
  end

  assign fifo.fifo_deq_o = deq;
  assign tx_o            = tx_reg;
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a registered upstream FIFO model and a UART receiver model.
// Expected line levels are derived from the byte value and the bit period.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DW    = 8;
  localparam int FRAME = (DW + 2) * CPB;

  logic clk = 1'b0;
  logic reset_i;
  logic tx_o;
  logic busy_o;

  uart_tx_fifo_if #(.DATA_WIDTH(DW)) fifo_bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk    (clk),
    .reset_i(reset_i),
    .fifo   (fifo_bus.master),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifo_mem[$];
  logic       toggle_mode   = 1'b0;
  logic       prev_deq      = 1'b0;
  int         deq_count     = 0;
  int         deq_empty_err = 0;
  int         deq_back_err  = 0;

  // Upstream FIFO: empty flag and head data are registered, so the head settles one cycle after a pop
  always @(posedge clk) begin
    if (fifo_bus.fifo_deq_o === 1'b1) begin
      deq_count++;
      if (fifo_bus.fifo_empty_i === 1'b1) deq_empty_err++;
      if (prev_deq) deq_back_err++;
      if (!toggle_mode && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
    end
    prev_deq <= (fifo_bus.fifo_deq_o === 1'b1);
    if (toggle_mode) begin
      fifo_bus.fifo_empty_i <= 1'b0;
      fifo_bus.fifo_q_i     <= 8'($urandom);
    end else begin
      fifo_bus.fifo_empty_i <= (fifo_mem.size() == 0);
      if (fifo_mem.size() > 0) fifo_bus.fifo_q_i <= fifo_mem[0];
    end
  end

  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  int         rx_slot;
  logic [7:0] rx_shift  = '0;
  logic [7:0] rx_mem[$];
  int         framing_err = 0;

  // Receiver samples mid-bit; an aborted frame is discarded when reset is seen
  always @(negedge clk) begin
    if (reset_i === 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx_o === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 1;
      end
    end else begin
      if (rx_cnt % CPB == CPB / 2) begin
        rx_slot = rx_cnt / CPB;
        if (rx_slot == 0) begin
          if (tx_o !== 1'b0) begin
            framing_err++;
            rx_active = 1'b0;
          end
        end else if (rx_slot <= DW) begin
          rx_shift[rx_slot-1] = tx_o;
        end else begin
          if (tx_o !== 1'b1) framing_err++;
          rx_mem.push_back(rx_shift);
          rx_active = 1'b0;
        end
      end
      rx_cnt++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_deq(input int limit, input string tag);
    int n = 0;
    @(negedge clk);
    n++;
    while (fifo_bus.fifo_deq_o !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(fifo_bus.fifo_deq_o), 32'(1));
  endtask

  // Walks the 160 cycles after the dequeue cycle; release_at stops the toggling FIFO mid-frame
  task automatic check_frame(input logic [7:0] data, input int release_at);
    int   slot;
    logic exp_bit;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (i == release_at) toggle_mode = 1'b0;
      slot = (i - 1) / CPB;
      if (slot == 0)       exp_bit = 1'b0;
      else if (slot > DW)  exp_bit = 1'b1;
      else                 exp_bit = data[slot-1];
      check_output($sformatf("tx_%0h_c%0d", data, i), 32'(tx_o), 32'(exp_bit));
      check_output($sformatf("busy_%0h_c%0d", data, i), 32'(busy_o), 32'(1));
      check_output($sformatf("deq_%0h_c%0d", data, i), 32'(fifo_bus.fifo_deq_o), 32'(0));
    end
  endtask

  task automatic check_rx(input logic [7:0] exp, input string tag);
    logic [7:0] got;
    check_output({tag, "_count"}, 32'(rx_mem.size() > 0), 32'(1));
    if (rx_mem.size() > 0) begin
      got = rx_mem.pop_front();
      check_output(tag, 32'(got), 32'(exp));
    end
  endtask

  // Directed sequence
  initial begin
    int         base;
    int         n;
    logic [7:0] captured;
    logic [7:0] exp_mem[$];
    logic [7:0] b;

    reset_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_output("rst_tx",   32'(tx_o), 32'(1));
      check_output("rst_busy", 32'(busy_o), 32'(0));
      check_output("rst_deq",  32'(fifo_bus.fifo_deq_o), 32'(0));
    end
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("idle_tx",   32'(tx_o), 32'(1));
      check_output("idle_busy", 32'(busy_o), 32'(0));
      check_output("idle_deq",  32'(fifo_bus.fifo_deq_o), 32'(0));
    end

    $display("[TB] single frame 0xA5");
    base = deq_count;
    fifo_mem.push_back(8'hA5);
    wait_deq(20, "deq_a5");
    check_frame(8'hA5, -1);
    @(negedge clk);
    check_output("a5_end_busy", 32'(busy_o), 32'(0));
    check_output("a5_end_tx",   32'(tx_o), 32'(1));
    check_output("a5_end_deq",  32'(fifo_bus.fifo_deq_o), 32'(0));
    check_output("a5_deq_count", 32'(deq_count - base), 32'(1));
    check_rx(8'hA5, "rx_a5");

    $display("[TB] back-to-back 0x00 0xFF 0x55");
    base = deq_count;
    fifo_mem.push_back(8'h00);
    fifo_mem.push_back(8'hFF);
    fifo_mem.push_back(8'h55);
    wait_deq(20, "deq_00");
    check_frame(8'h00, -1);
    @(negedge clk);
    check_output("gap1_deq",  32'(fifo_bus.fifo_deq_o), 32'(1));
    check_output("gap1_busy", 32'(busy_o), 32'(0));
    check_frame(8'hFF, -1);
    @(negedge clk);
    check_output("gap2_deq",  32'(fifo_bus.fifo_deq_o), 32'(1));
    check_frame(8'h55, -1);
    repeat (20) @(negedge clk);
    check_output("b2b_deq_count", 32'(deq_count - base), 32'(3));
    check_output("b2b_fifo_empty", 32'(fifo_bus.fifo_empty_i), 32'(1));
    check_output("b2b_mem_size", 32'(fifo_mem.size()), 32'(0));
    check_rx(8'h00, "rx_00");
    check_rx(8'hFF, "rx_ff");
    check_rx(8'h55, "rx_55");

    $display("[TB] reset during frame 0x3C");
    fifo_mem.push_back(8'h3C);
    wait_deq(20, "deq_3c");
    repeat (50) @(negedge clk);
    reset_i = 1'b1;
    fifo_mem.push_back(8'h81);
    base = deq_count;
    repeat (3) begin
      @(negedge clk);
      check_output("abort_tx",   32'(tx_o), 32'(1));
      check_output("abort_busy", 32'(busy_o), 32'(0));
      check_output("abort_deq",  32'(fifo_bus.fifo_deq_o), 32'(0));
    end
    check_output("abort_deq_count", 32'(deq_count - base), 32'(0));
    reset_i = 1'b0;
    #1;
    check_output("deq_after_reset", 32'(fifo_bus.fifo_deq_o), 32'(1));
    check_frame(8'h81, -1);
    @(negedge clk);
    check_rx(8'h81, "rx_81");
    check_output("rx_after_abort", 32'(rx_mem.size()), 32'(0));

    $display("[TB] head data toggling during frame");
    toggle_mode = 1'b1;
    wait_deq(20, "deq_toggle");
    captured = fifo_bus.fifo_q_i;
    check_frame(captured, 20);
    @(negedge clk);
    check_output("toggle_no_deq", 32'(fifo_bus.fifo_deq_o), 32'(0));
    check_output("toggle_empty",  32'(fifo_bus.fifo_empty_i), 32'(1));
    check_rx(captured, "rx_toggle");

    $display("[TB] 256 random bytes");
    rx_mem.delete();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      exp_mem.push_back(b);
      fifo_mem.push_back(b);
    end
    n = 0;
    while (rx_mem.size() < 256 && n < 256 * (FRAME + 1) + 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("stream_count", 32'(rx_mem.size()), 32'(256));
    for (int i = 0; i < 256; i++) begin
      if (i < rx_mem.size())
        check_output($sformatf("stream_%0d", i), 32'(rx_mem[i]), 32'(exp_mem[i]));
    end
    check_output("framing_errors", 32'(framing_err), 32'(0));
    check_output("deq_while_empty", 32'(deq_empty_err), 32'(0));
    check_output("deq_back_to_back", 32'(deq_back_err), 32'(0));
    check_output("stream_fifo_drained", 32'(fifo_mem.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per character.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fifo_q_i  input  DATA_WIDTH  character at the upstream FIFO head.
REQ-006 SHALL have port fifo_empty_i  input  1  upstream FIFO empty, registered by the FIFO.
REQ-007 SHALL have port fifo_deq_o  output  1  single-cycle dequeue strobe to the upstream FIFO.
REQ-008 SHALL have port tx_o  output  1  serial line, idle high.
REQ-009 SHALL have port busy_o  output  1  high while a frame is being shifted out.

Function
REQ-010 SHALL implement states IDLE, START, DATA, STOP.
REQ-011 In IDLE with fifo_empty_i low, SHALL assert fifo_deq_o for exactly one cycle, capture fifo_q_i into the shift register on that same edge, and go to START.
REQ-012 SHALL NOT assert fifo_deq_o while fifo_empty_i is high, and SHALL NOT assert it in outside IDLE.
REQ-013 SHALL never assert fifo_deq_o on two consecutive cycles; the FIFO head data needs one cycle to settle after a dequeue.
REQ-014 START SHALL drive tx_o low for CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA SHALL shift out DATA_WIDTH bits LSB first, CLKS_PER_BIT cycles each, using a bit index counter of width clog2(DATA_WIDTH), then go to STOP.
REQ-016 STOP SHALL drive tx_o high for CLKS_PER_BIT cycles, then return to IDLE.
REQ-017 The baud counter SHALL reload to CLKS_PER_BIT-1 on every state or bit change and count down to 0; width clog2(CLKS_PER_BIT).
REQ-018 tx_o SHALL be registered, with no combinational path from any input.
REQ-019 busy_o SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-020 Latency: the start bit falling edge on tx_o SHALL appear exactly 1 cycle after the fifo_deq_o cycle.
REQ-021 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the start-bit edge to the end of the stop bit.
REQ-022 Back-to-back: if fifo_empty_i is low when STOP completes, SHALL enter IDLE for exactly 1 cycle, dequeue there, and start the next frame with no added idle bit time.
REQ-023 fifo_empty_i going high mid-frame SHALL NOT affect the current frame.
REQ-024 fifo_q_i changes after the capture edge SHALL NOT affect the current frame.

Reset
REQ-025 While reset_i is high: state IDLE, tx_o=1, busy_o=0, fifo_deq_o=0, counters=0, shift register=0.
REQ-026 reset_i asserted mid-frame SHALL abort the frame; tx_o SHALL be high on the next cycle, and no dequeue SHALL occur until the cycle after reset_i deasserts.
REQ-027 The first cycle after reset deassertion SHALL be eligible for a dequeue if fifo_empty_i is low.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8, upstream FIFO model with 1-cycle read settle)
REQ-028 Reset held 5 cycles with FIFO empty -> tx_o=1, busy_o=0, fifo_deq_o=0 throughout and after release.
REQ-029 Enqueue 0xA5 -> exactly one deq pulse; tx_o low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles; busy_o high for 160 cycles.
REQ-030 Enqueue 0x00, 0xFF, 0x55 together -> three deq pulses spaced 161 cycles apart, three correct frames, FIFO empty at the end, no spurious fourth pulse.
REQ-031 Assert reset_i at cycle 50 of a frame of 0x3C -> tx_o=1 from the next cycle, busy_o=0, no deq while reset is high; after release with a queued 0x81, one clean frame of 0x81.
REQ-032 Hold fifo_empty_i low and toggle fifo_q_i every cycle during a frame -> the transmitted frame equals the value captured at the deq edge only.
REQ-033 Scoreboard: a UART receiver model at 16 cycles per bit decodes 256 random bytes streamed through the FIFO -> all match in order, zero framing errors.
